// File: rtl/ahb_dotprod_accel.sv
// AHB-Lite slave dot-product accelerator: two 8-entry signed 16-bit
// operand buffers and a one-MAC-per-cycle engine with a DONE interrupt.
module ahb_dotprod_accel #(
    parameter int AW     = 12,
    parameter int MAXLEN = 8
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic          HSEL,
    input  logic [AW-1:0] HADDR,
    input  logic [1:0]    HTRANS,
    input  logic [2:0]    HSIZE,
    input  logic          HWRITE,
    input  logic [31:0]   HWDATA,
    input  logic          HREADY,
    output logic          HREADYOUT,
    output logic [31:0]   HRDATA,
    output logic          HRESP,
    output logic          IRQ
);

    localparam int WA = AW - 2;
    localparam int IW = $clog2(MAXLEN);
    localparam logic [WA-1:0] OFF_CTRL   = WA'(16);
    localparam logic [WA-1:0] OFF_STATUS = WA'(17);
    localparam logic [WA-1:0] OFF_RESULT = WA'(18);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t          state_q, state_d;
    logic            dp_q, wr_q, word_q;
    logic [WA-1:0]   addr_q;
    logic [15:0]     a_q [MAXLEN];
    logic [15:0]     b_q [MAXLEN];
    logic [3:0]      len_q;
    logic            irqen_q;
    logic            done_q;
    logic            irq_q;
    logic [31:0]     result_q;
    logic [31:0]     acc_q;
    logic [IW-1:0]   idx_q;

    logic            capture, busy, wr_en;
    logic            a_we, b_we, ctrl_we, stat_we, start;
    logic [3:0]      len_wr;
    logic            acc_clr, mac_en, fin, zero_fin;
    logic [31:0]     a_ext, b_ext, prod, acc_sum;
    logic [31:0]     rdata;
    logic            unused_bits;

    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;
    assign IRQ       = irq_q;
    assign HRDATA    = rdata;

    assign capture = HSEL & HREADY & HTRANS[1];
    assign busy    = (state_q == RUN);
    assign wr_en   = dp_q & wr_q & word_q;

    // Operand and control writes are locked out while a run is in flight.
    assign a_we    = wr_en & ~busy & (addr_q[WA-1:IW] == '0);
    assign b_we    = wr_en & ~busy & (addr_q[WA-1:IW+1] == '0) & addr_q[IW];
    assign ctrl_we = wr_en & ~busy & (addr_q == OFF_CTRL);
    assign stat_we = wr_en & (addr_q == OFF_STATUS);
    assign start   = ctrl_we & HWDATA[0];
    assign len_wr  = (HWDATA[11:8] > 4'(MAXLEN)) ? 4'(MAXLEN) : HWDATA[11:8];

    // Sign-extend to 32 bits; the low 32 bits of the product are exact.
    assign a_ext   = {{16{a_q[idx_q][15]}}, a_q[idx_q]};
    assign b_ext   = {{16{b_q[idx_q][15]}}, b_q[idx_q]};
    assign prod    = a_ext * b_ext;
    assign acc_sum = acc_q + prod;

    assign unused_bits = ^{HADDR[1:0], HTRANS[0], HWDATA[31:16]};

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dp_q   <= 1'b0;
            wr_q   <= 1'b0;
            word_q <= 1'b0;
            addr_q <= '0;
        end else if (HREADY) begin
            dp_q <= capture;
            if (capture) begin
                wr_q   <= HWRITE;
                word_q <= (HSIZE == 3'b010);
                addr_q <= HADDR[AW-1:2];
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        acc_clr  = 1'b0;
        mac_en   = 1'b0;
        fin      = 1'b0;
        zero_fin = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (len_wr != 4'd0) begin
                        state_d = RUN;
                        acc_clr = 1'b1;
                    end else begin
                        zero_fin = 1'b1;
                    end
                end
            end
            RUN: begin
                mac_en = 1'b1;
                if (4'(idx_q) == len_q - 4'd1) begin
                    fin     = 1'b1;
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            for (int i = 0; i < MAXLEN; i++) begin
                a_q[i] <= '0;
                b_q[i] <= '0;
            end
            len_q    <= '0;
            irqen_q  <= 1'b0;
            done_q   <= 1'b0;
            irq_q    <= 1'b0;
            result_q <= '0;
            acc_q    <= '0;
            idx_q    <= '0;
        end else begin
            if (a_we) begin
                a_q[addr_q[IW-1:0]] <= HWDATA[15:0];
            end
            if (b_we) begin
                b_q[addr_q[IW-1:0]] <= HWDATA[15:0];
            end
            if (ctrl_we) begin
                irqen_q <= HWDATA[1];
                len_q   <= len_wr;
            end
            if (acc_clr) begin
                acc_q <= '0;
                idx_q <= '0;
            end else if (mac_en) begin
                acc_q <= acc_sum;
                idx_q <= idx_q + 1'b1;
            end
            // Completion takes priority over a coincident DONE clear.
            if (fin) begin
                result_q <= acc_sum;
                done_q   <= 1'b1;
            end else if (zero_fin) begin
                result_q <= '0;
                done_q   <= 1'b1;
            end else if (acc_clr) begin
                done_q <= 1'b0;
            end else if (stat_we && HWDATA[1]) begin
                done_q <= 1'b0;
            end
            irq_q <= done_q & irqen_q;
        end
    end

    always_comb begin
        rdata = '0;
        if (dp_q && !wr_q) begin
            if (addr_q[WA-1:IW] == '0) begin
                rdata = {16'b0, a_q[addr_q[IW-1:0]]};
            end else if (addr_q[WA-1:IW+1] == '0) begin
                rdata = {16'b0, b_q[addr_q[IW-1:0]]};
            end else if (addr_q == OFF_CTRL) begin
                rdata = {20'b0, len_q, 6'b0, irqen_q, 1'b0};
            end else if (addr_q == OFF_STATUS) begin
                rdata = {30'b0, done_q, busy};
            end else if (addr_q == OFF_RESULT) begin
                rdata = result_q;
            end
        end
    end

endmodule

// File: tb/tb_ahb_dotprod_accel.sv
// Directed bench for ahb_dotprod_accel: cycle-stepped AHB driver,
// hand-computed expected values, one checking task.
module tb_ahb_dotprod_accel;

    localparam logic [11:0] A_BASE = 12'h000;
    localparam logic [11:0] B_BASE = 12'h020;
    localparam logic [11:0] CTRL   = 12'h040;
    localparam logic [11:0] STATUS = 12'h044;
    localparam logic [11:0] RESULT = 12'h048;
    localparam logic [2:0]  WORD   = 3'b010;
    localparam logic [2:0]  BYTE   = 3'b000;

    logic        HCLK;
    logic        HRESETn;
    logic        HSEL;
    logic [11:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic [31:0] HRDATA;
    logic        HRESP;
    logic        IRQ;

    int n_checks = 0;
    int n_errors = 0;

    ahb_dotprod_accel #(.AW(12), .MAXLEN(8)) dut (
        .HCLK(HCLK),
        .HRESETn(HRESETn),
        .HSEL(HSEL),
        .HADDR(HADDR),
        .HTRANS(HTRANS),
        .HSIZE(HSIZE),
        .HWRITE(HWRITE),
        .HWDATA(HWDATA),
        .HREADY(HREADY),
        .HREADYOUT(HREADYOUT),
        .HRDATA(HRDATA),
        .HRESP(HRESP),
        .IRQ(IRQ)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One bus cycle: drive a new address phase plus write data for the
    // previous one; return this cycle's HRDATA sampled at the falling edge.
    task automatic cyc(input logic sel, input logic [11:0] addr,
                       input logic wr, input logic [2:0] size,
                       input logic [31:0] wdata, output logic [31:0] rdata);
        @(posedge HCLK);
        #1;
        HSEL   = sel;
        HTRANS = sel ? 2'b10 : 2'b00;
        HADDR  = addr;
        HWRITE = wr;
        HSIZE  = size;
        HWDATA = wdata;
        @(negedge HCLK);
        rdata = HRDATA;
    endtask

    task automatic wr(input logic [11:0] addr, input logic [31:0] data);
        logic [31:0] d;
        cyc(1'b1, addr, 1'b1, WORD, 32'h0, d);
        cyc(1'b0, 12'h0, 1'b0, WORD, data, d);
    endtask

    task automatic rd(input logic [11:0] addr, output logic [31:0] data);
        logic [31:0] d;
        cyc(1'b1, addr, 1'b0, WORD, 32'h0, d);
        cyc(1'b0, 12'h0, 1'b0, WORD, 32'h0, data);
    endtask

    task automatic idle(input int n);
        logic [31:0] d;
        for (int i = 0; i < n; i++) cyc(1'b0, 12'h0, 1'b0, WORD, 32'h0, d);
    endtask

    // Writes CTRL (data phase = cycle T) and polls STATUS every cycle.
    task automatic run(input string tag, input logic [31:0] ctrl,
                       input int len, input logic [31:0] exp_res,
                       input logic exp_irq);
        logic [31:0] d;
        logic [31:0] st [12];
        logic        irqs [12];
        cyc(1'b1, CTRL, 1'b1, WORD, 32'h0, d);
        cyc(1'b1, STATUS, 1'b0, WORD, ctrl, d);
        for (int k = 1; k <= len + 2; k++) begin
            cyc(1'b1, STATUS, 1'b0, WORD, 32'h0, d);
            st[k]   = d;
            irqs[k] = IRQ;
        end
        cyc(1'b0, 12'h0, 1'b0, WORD, 32'h0, d);
        if (len > 0) begin
            check({tag, "_busy_t1"}, st[1], 32'h1);
            check({tag, "_busy_last"}, st[len], 32'h1);
        end else begin
            check({tag, "_busy_never"}, {31'b0, st[2][0]}, 32'h0);
        end
        check({tag, "_done"}, st[len+1], 32'h2);
        check({tag, "_irq_pre"}, {31'b0, irqs[len+1]}, 32'h0);
        check({tag, "_irq"}, {31'b0, irqs[len+2]}, {31'b0, exp_irq});
        rd(RESULT, d);
        check({tag, "_result"}, d, exp_res);
    endtask

    initial begin
        logic [31:0] d;
        HRESETn = 1'b0;
        HSEL    = 1'b0;
        HADDR   = '0;
        HTRANS  = 2'b00;
        HSIZE   = WORD;
        HWRITE  = 1'b0;
        HWDATA  = '0;
        HREADY  = 1'b1;
        repeat (3) @(posedge HCLK);
        #1 HRESETn = 1'b1;

        check("rst_irq", {31'b0, IRQ}, 32'h0);
        check("rst_hreadyout", {31'b0, HREADYOUT}, 32'h1);
        check("rst_hresp", {31'b0, HRESP}, 32'h0);
        for (int i = 0; i < 20; i++) begin
            rd(12'(i * 4), d);
            check($sformatf("rst_reg_%0h", i * 4), d, 32'h0);
        end

        // 1*5 + 2*6 + 3*7 + 4*8 = 70
        for (int i = 0; i < 4; i++) begin
            wr(A_BASE + 12'(i * 4), 32'(i + 1));
            wr(B_BASE + 12'(i * 4), 32'(i + 5));
        end
        run("len4", 32'h0000_0403, 4, 32'd70, 1'b1);

        cyc(1'b1, STATUS, 1'b1, WORD, 32'h0, d);
        cyc(1'b1, STATUS, 1'b0, WORD, 32'h2, d);
        cyc(1'b0, 12'h0, 1'b0, WORD, 32'h0, d);
        check("w1c_done", d, 32'h0);
        check("w1c_irq_hold", {31'b0, IRQ}, 32'h1);
        idle(1);
        check("w1c_irq_clr", {31'b0, IRQ}, 32'h0);

        // 8 * 2^30 wraps to 0
        for (int i = 0; i < 8; i++) begin
            wr(A_BASE + 12'(i * 4), 32'h8000);
            wr(B_BASE + 12'(i * 4), 32'h8000);
        end
        run("full", 32'h0000_0803, 8, 32'h0, 1'b1);

        wr(A_BASE, 32'h0000_FFFF);
        wr(B_BASE, 32'h3);
        run("neg", 32'h0000_0103, 1, 32'hFFFF_FFFD, 1'b1);
        rd(A_BASE, d);
        check("a0_readback", d, 32'h0000_FFFF);

        wr(STATUS, 32'h2);
        idle(2);
        run("len0", 32'h0000_0003, 0, 32'h0, 1'b1);

        wr(CTRL, 32'h0000_0F02);
        rd(CTRL, d);
        check("len_clamp", d, 32'h0000_0802);

        // 1^2 + ... + 8^2 = 204; writes during the run must not land
        for (int i = 0; i < 8; i++) begin
            wr(A_BASE + 12'(i * 4), 32'(i + 1));
            wr(B_BASE + 12'(i * 4), 32'(i + 1));
        end
        wr(CTRL, 32'h0000_0803);
        wr(A_BASE + 12'h8, 32'h7FFF);
        wr(CTRL, 32'h0000_0101);
        cyc(1'b1, A_BASE + 12'h4, 1'b1, BYTE, 32'h0, d);
        cyc(1'b0, 12'h0, 1'b0, WORD, 32'hFF, d);
        idle(4);
        rd(RESULT, d);
        check("busy_result", d, 32'd204);
        rd(STATUS, d);
        check("busy_status", d, 32'h2);
        rd(A_BASE + 12'h8, d);
        check("busy_a2", d, 32'h3);
        rd(A_BASE + 12'h4, d);
        check("busy_a1", d, 32'h2);
        rd(CTRL, d);
        check("busy_ctrl", d, 32'h0000_0802);

        wr(CTRL, 32'h0000_0803);
        idle(3);
        HRESETn = 1'b0;
        #2;
        check("midrst_irq", {31'b0, IRQ}, 32'h0);
        @(posedge HCLK);
        #1 HRESETn = 1'b1;
        rd(STATUS, d);
        check("midrst_status", d, 32'h0);
        rd(RESULT, d);
        check("midrst_result", d, 32'h0);
        rd(CTRL, d);
        check("midrst_ctrl", d, 32'h0);
        rd(A_BASE, d);
        check("midrst_a0", d, 32'h0);
        rd(B_BASE + 12'h1C, d);
        check("midrst_b7", d, 32'h0);
        idle(6);
        rd(STATUS, d);
        check("midrst_no_resume", d, 32'h0);

        cyc(1'b1, A_BASE, 1'b1, WORD, 32'h0, d);
        cyc(1'b1, A_BASE, 1'b0, WORD, 32'h1234, d);
        cyc(1'b0, 12'h0, 1'b0, WORD, 32'h0, d);
        check("b2b_read_a0", d, 32'h1234);
        cyc(1'b1, B_BASE, 1'b1, BYTE, 32'h0, d);
        cyc(1'b0, 12'h0, 1'b0, WORD, 32'hAB, d);
        rd(B_BASE, d);
        check("b2b_byte_b0", d, 32'h0);
        check("hreadyout", {31'b0, HREADYOUT}, 32'h1);
        check("hresp", {31'b0, HRESP}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
